// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue path:
// control codes, ALUOp encodings and R-type funct values.
package alu_pkg;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;
    localparam logic [3:0] CTRL_EQ  = 4'b1111;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_FUNCT = 2'b10;
    localparam logic [1:0] OP_EQ    = 2'b11;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;

endpackage

// File: rtl/ALU_32.sv
// Combinational 32-bit ALU with zero, carry and
// signed-overflow flags (carry/overflow for add/sub only).
module ALU_32
    import alu_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ALU_ctrl,
    output logic [31:0] ALU_out,
    output logic        zero,
    output logic        carry_out,
    output logic        overflow
);

    logic [32:0] add_full;
    logic [32:0] sub_full;

    assign add_full = {1'b0, A} + {1'b0, B};
    assign sub_full = {1'b0, A} + {1'b0, ~B} + 33'd1;

    // Select the operation; flags default to 0 for logic ops.
    always_comb begin
        ALU_out   = 32'd0;
        carry_out = 1'b0;
        overflow  = 1'b0;
        case (ALU_ctrl)
            CTRL_AND: ALU_out = A & B;
            CTRL_OR:  ALU_out = A | B;
            CTRL_NOR: ALU_out = ~(A | B);
            CTRL_ADD: begin
                ALU_out   = add_full[31:0];
                carry_out = add_full[32];
                overflow  = (A[31] == B[31]) &&
                            (add_full[31] != A[31]);
            end
            CTRL_SUB: begin
                ALU_out   = sub_full[31:0];
                carry_out = sub_full[32];
                overflow  = (A[31] != B[31]) &&
                            (sub_full[31] != A[31]);
            end
            CTRL_SLT: ALU_out = {31'd0, $signed(A) < $signed(B)};
            CTRL_EQ:  ALU_out = {31'd0, A == B};
            default:  ALU_out = 32'd0;
        endcase
    end

    assign zero = (ALU_out == 32'd0);

endmodule

// File: rtl/alu_ctrl_decode.sv
// Maps (ALUOp, funct) to the 4-bit ALU control code.
// Unknown funct values yield ctrl 0000 with illegal set.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] ctrl,
    output logic       illegal
);

    // Pure combinational decode; funct only matters for ALUOp 10.
    always_comb begin
        ctrl    = CTRL_AND;
        illegal = 1'b0;
        unique case (alu_op)
            OP_ADD: ctrl = CTRL_ADD;
            OP_SUB: ctrl = CTRL_SUB;
            OP_EQ:  ctrl = CTRL_EQ;
            default: begin
                case (funct)
                    F_ADD:   ctrl = CTRL_ADD;
                    F_SUB:   ctrl = CTRL_SUB;
                    F_AND:   ctrl = CTRL_AND;
                    F_OR:    ctrl = CTRL_OR;
                    F_NOR:   ctrl = CTRL_NOR;
                    F_SLT:   ctrl = CTRL_SLT;
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage issue/retire wrapper around ALU_32 with
// valid/ready on both sides and a completion counter.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_alu_op,
    input  logic [5:0]       in_funct,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      out_count
);

    logic             s1_valid;
    logic [3:0]       s1_ctrl;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_illegal;

    logic [3:0]       dec_ctrl;
    logic             dec_illegal;

    logic [31:0]      alu_out;
    logic             alu_zero;
    logic             alu_carry;
    logic             alu_ovf;

    logic             s2_load;
    logic             accept;
    logic             drain;

    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    alu_ctrl_decode u_dec (
        .alu_op  (in_alu_op),
        .funct   (in_funct),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    ALU_32 u_alu (
        .A         (s1_a),
        .B         (s1_b),
        .ALU_ctrl  (s1_ctrl),
        .ALU_out   (alu_out),
        .zero      (alu_zero),
        .carry_out (alu_carry),
        .overflow  (alu_ovf)
    );

    // Issue register: load on accept, empty when S2 takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_ctrl    <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_tag     <= '0;
            s1_illegal <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_ctrl    <= dec_ctrl;
            s1_a       <= in_a;
            s1_b       <= in_b;
            s1_tag     <= in_tag;
            s1_illegal <= dec_illegal;
        end else if (s2_load) begin
            s1_valid   <= 1'b0;
        end
    end

    // Retire register: capture ALU outputs, illegal ops read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_zero     <= 1'b0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
            out_illegal  <= 1'b0;
            out_tag      <= '0;
        end else if (s2_load) begin
            out_valid    <= 1'b1;
            out_result   <= s1_illegal ? '0 : alu_out;
            out_zero     <= !s1_illegal && alu_zero;
            out_carry    <= !s1_illegal && alu_carry;
            out_overflow <= !s1_illegal && alu_ovf;
            out_illegal  <= s1_illegal;
            out_tag      <= s1_tag;
        end else if (drain) begin
            out_valid    <= 1'b0;
        end
    end

    // Count completed output handshakes, wrapping at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_count <= 16'd0;
        end else if (drain) begin
            out_count <= out_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: reset flush, decode,
// back-pressure ordering, illegal override and counter wrap.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_alu_op;
    logic [5:0]  in_funct;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_carry;
    logic        out_overflow;
    logic        out_illegal;
    logic [3:0]  out_tag;
    logic [15:0] out_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.WIDTH(32), .TAG_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_alu_op    (in_alu_op),
        .in_funct     (in_funct),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_illegal  (out_illegal),
        .out_tag      (out_tag),
        .out_count    (out_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t);
        in_valid  = 1'b1;
        in_alu_op = op;
        in_funct  = fn;
        in_a      = a;
        in_b      = b;
        in_tag    = t;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_alu_op = 2'b00;
        in_funct  = 6'd0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        in_tag    = 4'd0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_result", out_result, 32'd0);
        rst = 1'b0;
        step();

        // two ops in flight, then reset mid-stream
        drive(2'b00, 6'd0, 32'd5, 32'd6, 4'd9);
        step();
        drive(2'b00, 6'd0, 32'd7, 32'd8, 4'd10);
        step();
        in_valid = 1'b0;
        chk("flight_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_count", 32'(out_count), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();
        chk("post_rst_no_out", 32'(out_valid), 32'd0);
        chk("post_rst_count", 32'(out_count), 32'd0);

        // AND through funct decode
        drive(2'b10, 6'b100100, 32'h086a0c31, 32'hd785f148, 4'd5);
        step();
        in_valid = 1'b0;
        chk("and_latency", 32'(out_valid), 32'd0);
        step();
        chk("and_valid", 32'(out_valid), 32'd1);
        chk("and_result", out_result, 32'h0);
        chk("and_zero", 32'(out_zero), 32'd1);
        chk("and_illegal", 32'(out_illegal), 32'd0);
        chk("and_tag", 32'(out_tag), 32'd5);
        step();
        chk("and_count", 32'(out_count), 32'd1);

        // clean counter, then add/sub back-to-back
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(2'b00, 6'd0, 32'ha86a0c31, 32'h90073fd4, 4'd1);
        step();
        drive(2'b01, 6'd0, 32'ha86a0c31, 32'h90073fd4, 4'd2);
        step();
        in_valid = 1'b0;
        chk("add_result", out_result, 32'h38714c05);
        chk("add_carry", 32'(out_carry), 32'd1);
        chk("add_ovf", 32'(out_overflow), 32'd1);
        chk("add_tag", 32'(out_tag), 32'd1);
        step();
        chk("sub_valid", 32'(out_valid), 32'd1);
        chk("sub_result", out_result, 32'h1862cc5d);
        chk("sub_tag", 32'(out_tag), 32'd2);
        step();
        chk("addsub_count", 32'(out_count), 32'd2);
        chk("addsub_idle", 32'(out_valid), 32'd0);

        // back-pressure: four tagged ops, result equals tag
        out_ready = 1'b0;
        drive(2'b00, 6'd0, 32'd1, 32'd0, 4'd1);
        chk("bp_ready0", 32'(in_ready), 32'd1);
        step();
        drive(2'b00, 6'd0, 32'd2, 32'd0, 4'd2);
        chk("bp_ready1", 32'(in_ready), 32'd1);
        step();
        drive(2'b00, 6'd0, 32'd3, 32'd0, 4'd3);
        for (int i = 0; i < 5; i++) begin
            chk("bp_full_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_tag", 32'(out_tag), 32'd1);
            chk("bp_hold_res", out_result, 32'd1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        drive(2'b00, 6'd0, 32'd4, 32'd0, 4'd4);
        chk("bp_out2_valid", 32'(out_valid), 32'd1);
        chk("bp_out2_tag", 32'(out_tag), 32'd2);
        step();
        in_valid = 1'b0;
        chk("bp_out3_valid", 32'(out_valid), 32'd1);
        chk("bp_out3_tag", 32'(out_tag), 32'd3);
        step();
        chk("bp_out4_valid", 32'(out_valid), 32'd1);
        chk("bp_out4_tag", 32'(out_tag), 32'd4);
        chk("bp_out4_res", out_result, 32'd4);
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_count", 32'(out_count), 32'd6);

        // illegal funct followed by a legal add
        drive(2'b10, 6'b000011, 32'hffffffff, 32'd1, 4'd7);
        step();
        drive(2'b00, 6'd0, 32'd1, 32'd2, 4'd8);
        step();
        in_valid = 1'b0;
        chk("ill_flag", 32'(out_illegal), 32'd1);
        chk("ill_result", out_result, 32'd0);
        chk("ill_zero", 32'(out_zero), 32'd0);
        chk("ill_carry", 32'(out_carry), 32'd0);
        chk("ill_ovf", 32'(out_overflow), 32'd0);
        chk("ill_tag", 32'(out_tag), 32'd7);
        step();
        chk("legal_flag", 32'(out_illegal), 32'd0);
        chk("legal_result", out_result, 32'd3);
        chk("legal_tag", 32'(out_tag), 32'd8);
        step();

        // counter wrap with a continuous stream
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(2'b00, 6'd0, 32'd1, 32'd1, 4'd3);
        for (int i = 0; i < 70000 && out_count != 16'hffff; i++) begin
            step();
        end
        in_valid = 1'b0;
        chk("wrap_preload", 32'(out_count), 32'h0000ffff);
        chk("wrap_valid", 32'(out_valid), 32'd1);
        step();
        chk("wrap_count", 32'(out_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Two-stage pipelined issue/retire wrapper around the existing combinational 32-bit ALU (`ALU_32`). It accepts MIPS-style ALUOp/funct requests with operands on a valid/ready input channel. It decodes each request to the 4-bit ALU control code, registers the operands and drives the ALU. It then captures the ALU result and flags into an output register on a valid/ready output channel, giving the datapath a back-pressurable, one-op-per-cycle ALU stage.

## Interface
- `WIDTH`, 32: operand/result width; must equal ALU width.
- `TAG_W`, 4: width of the opaque request tag carried alongside each op.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1 / `in_ready` out 1: input handshake.
- `in_alu_op` in 2: 00 add, 01 sub, 11 equal, 10 decode from funct.
- `in_funct` in 6: R-type funct; used only when `in_alu_op`=10.
- `in_a`, `in_b` in WIDTH: operands. `in_tag` in TAG_W: request tag.
- `out_valid` out 1 / `out_ready` in 1: output handshake.
- `out_result` out WIDTH; `out_zero`, `out_carry`, `out_overflow` out 1: captured ALU outputs.
- `out_illegal` out 1: op had an undecodable funct. `out_tag` out TAG_W: tag of the op.
- `out_count` out 16: number of completed output handshakes since reset.

## Operation
- Decode to `ALU_ctrl`:
  - ALUOp 00 → 0010; ALUOp 01 → 0110; ALUOp 11 → 1111.
  - ALUOp 10 with funct 100000 → 0010; 100010 → 0110; 100100 → 0000; 100101 → 0001; 100111 → 1100; 101010 → 0111.
  - Any other funct → illegal. The op still flows through the pipeline with ctrl 0000, and the output side forces result 0, all flags 0, and `out_illegal`=1.
- Stage S1 (issue register) holds `s1_valid`, the decoded ctrl, A, B, tag and the illegal bit. S1 drives the internal `ALU_32` instance combinationally.
- Stage S2 (retire register) holds `out_valid` and the captured ALU_out, zero, carry_out, overflow, plus the tag and illegal bit.
- Advance rules:
  - `s2_load = s1_valid && (!out_valid || out_ready)`.
  - `in_ready = !s1_valid || s2_load`. This is combinational from `out_ready`, with no registered ready.
  - S1 loads on `in_valid && in_ready`. Otherwise it clears `s1_valid` when `s2_load`. Otherwise it holds.
  - S2 loads on `s2_load`. Otherwise it clears `out_valid` on `out_valid && out_ready`. Otherwise it holds.
- While `out_valid && !out_ready`, all `out_*` are held stable. No op is ever dropped or duplicated.
- `out_count` increments by 1 on each `out_valid && out_ready` and wraps 0xFFFF → 0x0000.
- ALU arithmetic/flag semantics belong to `ALU_32`. This block adds no width extension and no flag modification, except the illegal-op override.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert expected externally): `s1_valid`=0, `out_valid`=0. All S1/S2 data and `out_*` are 0, `out_count`=0. `in_ready`=1 during and after reset.
- Latency: an op accepted at edge N has `out_valid`=1 after edge N+1, assuming no stall.
- Throughput: 1 op/cycle with `out_ready` held at 1.
- Full condition: both stages valid and `out_ready`=0 → `in_ready`=0.
- Simultaneous input accept and output drain in the same cycle is legal when full; the pipeline shifts by one and no bubble is inserted.
- Reset asserted mid-operation discards both in-flight ops immediately. No output handshake occurs for them and `out_count` is not incremented.

## Structure
- Shared package `alu_pkg` holds:
  - ALU ctrl localparams: CTRL_AND=0000, CTRL_OR=0001, CTRL_ADD=0010, CTRL_SUB=0110, CTRL_SLT=0111, CTRL_NOR=1100, CTRL_EQ=1111.
  - ALUOp codes.
  - Funct constants.
- One sub-module is natural: `alu_ctrl_decode`, a combinational function of (alu_op, funct) → (ctrl, illegal), reused later by the main decoder.
- `ALU_32` is instantiated unmodified inside this block.

## Test plan
- Reset/idle: hold `rst`=1 mid-stream with 2 ops in flight → `out_valid`=0, `out_count`=0, `in_ready`=1. No op emerges after release.
- AND via funct 100100: A=086a0c31, B=d785f148, `out_ready`=1 → two cycles later `out_result`=00000000, `out_zero`=1, `out_illegal`=0, tag echoed.
- Add then sub back-to-back (ALUOp 00, then 01; A=a86a0c31, B=90073fd4):
  - Results appear on consecutive cycles: 38714c05 with carry=1, overflow=1; then 1862cc5d.
  - `out_count` ends at 2.
- Back-pressure: issue 4 ops with tags 1–4, holding `out_ready`=0 for 5 cycles:
  - `in_ready` drops after 2 accepts and `out_*` stay constant.
  - After release, tags 1–4 emerge in order with no gaps.
- Illegal funct 000011 with A=ffffffff, B=1 → `out_illegal`=1, `out_result`=0, zero=carry=overflow=0. The following legal op is unaffected.
- Counter wrap: preload by running 65535 handshakes, then 1 more → `out_count`=0000.
